// File: rtl/monkey_key_decoder.sv
// PS/2 scan-code decoder for the monkey direction keys.
// Each direction output is the OR of arrow-held, WASD-held and a per-frame sticky press.
module monkey_key_decoder #(
  parameter int TIMEOUT_CYCLES = 63000,
  parameter bit ENABLE_WASD    = 1'b1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [7:0] scanByte,
  input  logic       byteValid,
  output logic       leftPressed,
  output logic       rightPressed,
  output logic       upPressed,
  output logic       downPressed,
  output logic       keyEvent
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   toCnt_q, toCnt_d;
  logic [3:0]      heldExt_q, heldExt_d;
  logic [3:0]      heldStd_q, heldStd_d;
  logic [3:0]      sticky_q, sticky_d;
  logic [3:0]      dir_q, dir_d;
  logic            keyEvent_q, keyEvent_d;

  logic [3:0]      makeExt, brkExt, makeStd, brkStd;
  logic [3:0]      extCode, stdCode;

  // Direction one-hot: bit0 left, bit1 right, bit2 up, bit3 down.
  always_comb begin
    extCode = '0;
    case (scanByte)
      8'h6B:   extCode = 4'b0001;
      8'h74:   extCode = 4'b0010;
      8'h75:   extCode = 4'b0100;
      8'h72:   extCode = 4'b1000;
      default: extCode = '0;
    endcase
  end

  always_comb begin
    stdCode = '0;
    if (ENABLE_WASD) begin
      case (scanByte)
        8'h1C:   stdCode = 4'b0001;
        8'h23:   stdCode = 4'b0010;
        8'h1D:   stdCode = 4'b0100;
        8'h1B:   stdCode = 4'b1000;
        default: stdCode = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      toCnt_q <= '0;
    end else begin
      state_q <= state_d;
      toCnt_q <= toCnt_d;
    end
  end

  // A byte always takes priority over the timeout, since it restarts the counter.
  always_comb begin
    state_d = state_q;
    toCnt_d = (byteValid || state_q == IDLE) ? '0 : toCnt_q + 1'b1;
    if (byteValid) begin
      case (state_q)
        IDLE:    state_d = (scanByte == 8'hE0) ? EXT :
                           (scanByte == 8'hF0) ? BRK : IDLE;
        EXT:     state_d = (scanByte == 8'hF0) ? EXT_BRK :
                           (scanByte == 8'hE0) ? EXT : IDLE;
        BRK:     state_d = (scanByte == 8'hF0) ? BRK :
                           (scanByte == 8'hE0) ? EXT : IDLE;
        EXT_BRK: state_d = (scanByte == 8'hF0) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && toCnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    makeExt = '0;
    brkExt  = '0;
    makeStd = '0;
    brkStd  = '0;
    if (byteValid) begin
      case (state_q)
        IDLE:    makeStd = stdCode;
        EXT:     makeExt = extCode;
        BRK:     brkStd  = stdCode;
        EXT_BRK: brkExt  = extCode;
        default: ;
      endcase
    end
  end

  always_comb begin
    heldExt_d  = (heldExt_q | makeExt) & ~brkExt;
    heldStd_d  = (heldStd_q | makeStd) & ~brkStd;
    sticky_d   = (sticky_q & ~{4{startOfFrame}}) | makeExt | makeStd;
    dir_d      = heldExt_d | heldStd_d | sticky_d;
    keyEvent_d = |{makeExt, brkExt, makeStd, brkStd};
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      heldExt_q  <= '0;
      heldStd_q  <= '0;
      sticky_q   <= '0;
      dir_q      <= '0;
      keyEvent_q <= 1'b0;
    end else begin
      heldExt_q  <= heldExt_d;
      heldStd_q  <= heldStd_d;
      sticky_q   <= sticky_d;
      dir_q      <= dir_d;
      keyEvent_q <= keyEvent_d;
    end
  end

  assign leftPressed  = dir_q[0];
  assign rightPressed = dir_q[1];
  assign upPressed    = dir_q[2];
  assign downPressed  = dir_q[3];
  assign keyEvent     = keyEvent_q;

endmodule

// File: tb/tb_monkey_key_decoder.sv
// Directed bench for monkey_key_decoder; outputs checked #1 after each rising edge.
module tb_monkey_key_decoder;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic [7:0] scanByte;
  logic       byteValid;
  logic       leftPressed, rightPressed, upPressed, downPressed, keyEvent;
  logic       l1, r1, u1, d1, ke1;

  int checks   = 0;
  int failures = 0;

  monkey_key_decoder #(.TIMEOUT_CYCLES(16), .ENABLE_WASD(1'b1)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .scanByte(scanByte), .byteValid(byteValid),
    .leftPressed(leftPressed), .rightPressed(rightPressed),
    .upPressed(upPressed), .downPressed(downPressed), .keyEvent(keyEvent)
  );

  monkey_key_decoder #(.TIMEOUT_CYCLES(16), .ENABLE_WASD(1'b0)) dut_nowasd (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .scanByte(scanByte), .byteValid(byteValid),
    .leftPressed(l1), .rightPressed(r1),
    .upPressed(u1), .downPressed(d1), .keyEvent(ke1)
  );

  always #5 clk = ~clk;

  wire [3:0] dirs  = {downPressed, upPressed, rightPressed, leftPressed};
  wire [3:0] dirs1 = {d1, u1, r1, l1};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic sof = 1'b0);
    scanByte = b; byteValid = 1'b1; startOfFrame = sof;
    @(posedge clk); #1;
    byteValid = 1'b0; startOfFrame = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; scanByte = '0; byteValid = 1'b0;
    idle(3);
    chk("reset_dirs", dirs, 4'b0000);
    chk("reset_ke", {3'b0, keyEvent}, 4'b0);
    resetN = 1'b1;
    idle(1);

    // Up arrow make, frame boundary, break
    send(8'hE0); chk("t1_prefix_ke", {3'b0, keyEvent}, 4'b0);
    chk("t1_prefix_dirs", dirs, 4'b0000);
    send(8'h75); chk("t1_make_up", dirs, 4'b0100);
    chk("t1_make_ke", {3'b0, keyEvent}, 4'b1);
    chk("t1_nowasd_ext", dirs1, 4'b0100);
    idle(1);     chk("t1_ke_one_cycle", {3'b0, keyEvent}, 4'b0);
    sof_pulse(); chk("t1_held_after_sof", dirs, 4'b0100);
    send(8'hE0); send(8'hF0);
    chk("t1_brk_prefix_ke", {3'b0, keyEvent}, 4'b0);
    chk("t1_brk_prefix_up", dirs, 4'b0100);
    send(8'h75); chk("t1_break_up", dirs, 4'b0000);
    chk("t1_break_ke", {3'b0, keyEvent}, 4'b1);

    // Short tap of left arrow inside one frame
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk("t2_tap_sticky", dirs, 4'b0001);
    idle(3);     chk("t2_tap_hold", dirs, 4'b0001);
    sof_pulse(); chk("t2_tap_cleared", dirs, 4'b0000);

    // W and up arrow tracked independently
    send(8'h1D); chk("t3_w_make", dirs, 4'b0100);
    send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h1D);
    chk("t3_w_break_ke", {3'b0, keyEvent}, 4'b1);
    sof_pulse(); chk("t3_arrow_still_held", dirs, 4'b0100);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t3_all_released", dirs, 4'b0000);
    sof_pulse(); chk("t3_after_sof", dirs, 4'b0000);

    // Timeout: 16 idle cycles after E0 abandons the prefix, 15 does not
    send(8'hE0); idle(16); send(8'h74);
    chk("t4_timeout_right", dirs, 4'b0000);
    chk("t4_timeout_ke", {3'b0, keyEvent}, 4'b0);
    send(8'hE0); idle(15); send(8'h74);
    chk("t4_edge_right", dirs, 4'b0010);
    send(8'h23); chk("t4_d_make", dirs, 4'b0010);
    chk("t4_d_ke", {3'b0, keyEvent}, 4'b1);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hF0); send(8'h23);
    sof_pulse(); chk("t4_cleared", dirs, 4'b0000);

    // S make coincident with startOfFrame: set wins
    send(8'h1B, 1'b1); chk("t5_make_with_sof", dirs, 4'b1000);
    sof_pulse();       chk("t5_s_held", dirs, 4'b1000);
    send(8'hF0); send(8'h1B);
    chk("t5_s_break", dirs, 4'b0000);

    // Reset in the middle of a break sequence while left is held
    send(8'hE0); send(8'h6B); chk("t6_left_held", dirs, 4'b0001);
    send(8'hE0); send(8'hF0);
    resetN = 1'b0; idle(1); resetN = 1'b1;
    chk("t6_reset_dirs", dirs, 4'b0000);
    chk("t6_reset_ke", {3'b0, keyEvent}, 4'b0);
    send(8'h6B); chk("t6_bare_6b", dirs, 4'b0000);
    chk("t6_bare_6b_ke", {3'b0, keyEvent}, 4'b0);
    send(8'h1C); chk("t6_a_make", dirs, 4'b0001);
    chk("t6_nowasd_a", dirs1, 4'b0000);
    idle(1);
    send(8'h1C); chk("t6_repeat_ke", {3'b0, keyEvent}, 4'b1);
    chk("t6_repeat_left", dirs, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
